// File: rtl/reg_transport.sv
// reg_transport
// Transport record used to carry a register writeback (destination index and
// value) between pipeline stages and the register file.
//   reg_transport_t.addr  : destination register index (0 means x0, no write)
//   reg_transport_t.value : value to be written
package reg_transport;
    typedef struct packed {
        logic [rv32_isa::RegAddrWidth-1:0] addr;
        logic [rv32_isa::RegWidth-1:0]     value;
    } reg_transport_t;
endpackage

// File: rtl/rv32_isa.sv
// rv32_isa
// Architectural constants of the RV32 integer register file that other
// blocks size their datapaths from.
//   RegWidth     : width of one architectural register value
//   RegAddrWidth : width of a register index (x0..x31)
package rv32_isa;
    localparam int RegWidth     = 32;
    localparam int RegAddrWidth = 5;
endpackage

// File: rtl/reg_wb_lookup.sv
// reg_wb_lookup
// Youngest-match search over the writeback buffer slots for one operand
// bypass port. Purely combinational.
// Ports:
//   lk_addr     : register index being looked up (0 never hits)
//   entries     : all buffer slots, indexed by physical slot number
//   entry_valid : per-slot occupied flag
//   wr_ptr      : next slot to be written; the slot just behind it is the
//                 youngest occupied one
//   hit         : some occupied slot holds lk_addr
//   value       : value of the youngest such slot, 0 when no hit
module reg_wb_lookup
    import rv32_isa::*;
    import reg_transport::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [RegAddrWidth-1:0]    lk_addr,
    input  reg_transport_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]           entry_valid,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic                       hit,
    output logic [RegWidth-1:0]        value
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = entry_valid[gi] && (entries[gi].addr == lk_addr);
        end
    endgenerate

    // Walk the slots from oldest to youngest starting at wr_ptr (when full,
    // wr_ptr is the oldest slot; otherwise the slots at wr_ptr are empty and
    // never match). A later match overwrites an earlier one, so the youngest
    // matching slot ends up on the output.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        idx   = '0;
        if (lk_addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = wr_ptr + PTR_W'(k);
                if (match[idx]) begin
                    hit   = 1'b1;
                    value = entries[idx].value;
                end
            end
        end
    end

endmodule

// File: rtl/reg_wb_buffer.sv
// reg_wb_buffer
// Small FIFO of pending register writebacks sitting in front of the register
// file, with two operand bypass lookups that return the youngest buffered
// value for a register index.
// Ports:
//   clk, nRst              : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      : upstream writeback handshake
//   in_data                : writeback {addr, value}; addr 0 is accepted and dropped
//   out_valid/out_ready    : oldest entry handshake towards the register file
//   out_data               : oldest entry (0 when empty)
//   lk_a_addr/lk_b_addr    : bypass lookup register indices
//   lk_a_hit/lk_b_hit      : an occupied entry matches
//   lk_a_value/lk_b_value  : youngest matching value (0 when no hit)
//   count                  : number of occupied entries
module reg_wb_buffer
    import rv32_isa::*;
    import reg_transport::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  reg_transport_t            in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output reg_transport_t            out_data,
    input  logic [RegAddrWidth-1:0]   lk_a_addr,
    input  logic [RegAddrWidth-1:0]   lk_b_addr,
    output logic                      lk_a_hit,
    output logic                      lk_b_hit,
    output logic [RegWidth-1:0]       lk_a_value,
    output logic [RegWidth-1:0]       lk_b_value,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    reg_transport_t [DEPTH-1:0] entry_all;
    logic [DEPTH-1:0]           valid_all;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic push;
    logic store;
    logic pop;

    // in_ready depends on occupancy only, so a full buffer refuses a push
    // even in the cycle it is being popped.
    assign in_ready  = (count_reg < DEPTH_C);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    // Writebacks to x0 complete the handshake but never occupy a slot.
    assign store     = push && (in_data.addr != '0);
    assign pop       = out_valid && out_ready;

    // Head of the queue straight from the slot flops; forced to 0 when empty.
    assign out_data  = out_valid ? entry_all[rd_ptr_reg] : '0;
    assign count     = count_reg;

    // Per-slot storage. A slot is written only when it is the free slot at
    // wr_ptr and cleared only when it is the occupied slot at rd_ptr, so the
    // two never collide (that would require a push while full).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            reg_transport_t slot_reg;
            logic           slot_valid_reg;

            always_ff @(posedge clk or negedge nRst) begin
                if (!nRst) begin
                    slot_reg       <= '0;
                    slot_valid_reg <= 1'b0;
                end else begin
                    if (store && (wr_ptr_reg == PTR_W'(gi))) begin
                        slot_reg       <= in_data;
                        slot_valid_reg <= 1'b1;
                    end else if (pop && (rd_ptr_reg == PTR_W'(gi))) begin
                        slot_valid_reg <= 1'b0;
                    end
                end
            end

            assign entry_all[gi] = slot_reg;
            assign valid_all[gi] = slot_valid_reg;
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (store) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({store, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    reg_wb_lookup #(
        .DEPTH(DEPTH)
    ) u_lookup_a (
        .lk_addr     (lk_a_addr),
        .entries     (entry_all),
        .entry_valid (valid_all),
        .wr_ptr      (wr_ptr_reg),
        .hit         (lk_a_hit),
        .value       (lk_a_value)
    );

    reg_wb_lookup #(
        .DEPTH(DEPTH)
    ) u_lookup_b (
        .lk_addr     (lk_b_addr),
        .entries     (entry_all),
        .entry_valid (valid_all),
        .wr_ptr      (wr_ptr_reg),
        .hit         (lk_b_hit),
        .value       (lk_b_value)
    );

endmodule
